oitf_scoreboard: RTL and testbench

- Parametrised outstanding-instruction-track FIFO (OITF) for the MIPS pipeline.
- Records every long-latency instruction (load, LL/SC, mul/div) at issue: its destination register index and whether it writes LLbit.
- Retires entries in order at write-back.
- Gives decode combinational RAW/WAW hazard flags on rs1/rs2/rd and an LLbit hazard flag, so decode can stall until the conflicting producer retires.

---
 rtl/oitf_pkg.sv | 14 +
 rtl/oitf_scoreboard_if.sv | 46 ++++
 rtl/oitf_entry.sv | 57 +++++
 rtl/oitf_scoreboard.sv | 82 ++++++++
 tb/tb_oitf_scoreboard.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/oitf_pkg.sv
// Shared constants and the entry record for the outstanding-instruction-track FIFO.
package oitf_pkg;

  localparam int OITF_DEPTH_DEF = 4;
  localparam int REG_AW         = 5;

  typedef struct packed {
    logic              vld;
    logic              rdwen;
    logic              llbit;
    logic [REG_AW-1:0] rdidx;
  } oitf_entry_t;

endpackage

// File: rtl/oitf_scoreboard_if.sv
// Issue/retire/decode signal bundle between the pipeline (master) and the OITF (slave).
interface oitf_scoreboard_if #(
  parameter int DEPTH  = oitf_pkg::OITF_DEPTH_DEF,
  parameter int REG_AW = oitf_pkg::REG_AW
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              flush;
  logic              alc_vld;
  logic              alc_rdy;
  logic [REG_AW-1:0] alc_rdidx;
  logic              alc_rdwen;
  logic              alc_llbit;
  logic [PTR_W-1:0]  alc_ptr;
  logic              ret_vld;
  logic [PTR_W-1:0]  ret_ptr;
  logic              rs1_en;
  logic              rs2_en;
  logic              rd_en;
  logic [REG_AW-1:0] rs1_idx;
  logic [REG_AW-1:0] rs2_idx;
  logic [REG_AW-1:0] rd_idx;
  logic              llbit_rd;
  logic              rs1_match;
  logic              rs2_match;
  logic              rd_match;
  logic              llbit_match;
  logic              empty;
  logic              full;
  logic [PTR_W:0]    count;

  modport master (
    output flush, alc_vld, alc_rdidx, alc_rdwen, alc_llbit, ret_vld,
           rs1_en, rs2_en, rd_en, rs1_idx, rs2_idx, rd_idx, llbit_rd,
    input  alc_rdy, alc_ptr, ret_ptr, rs1_match, rs2_match, rd_match,
           llbit_match, empty, full, count
  );

  modport slave (
    input  flush, alc_vld, alc_rdidx, alc_rdwen, alc_llbit, ret_vld,
           rs1_en, rs2_en, rd_en, rs1_idx, rs2_idx, rd_idx, llbit_rd,
    output alc_rdy, alc_ptr, ret_ptr, rs1_match, rs2_match, rd_match,
           llbit_match, empty, full, count
  );

endinterface

// File: rtl/oitf_entry.sv
// One OITF slot: valid/destination registers plus its hazard comparators.
module oitf_entry #(
  parameter int REG_AW = oitf_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_set,
  input  logic              i_clr,
  input  logic [REG_AW-1:0] i_rdidx,
  input  logic              i_rdwen,
  input  logic              i_llbit,
  input  logic [REG_AW-1:0] i_rs1_idx,
  input  logic [REG_AW-1:0] i_rs2_idx,
  input  logic [REG_AW-1:0] i_rd_idx,
  output logic              o_rs1_hit,
  output logic              o_rs2_hit,
  output logic              o_rd_hit,
  output logic              o_llbit_hit
);

  logic              r_vld;
  logic              r_rdwen;
  logic              r_llbit;
  logic [REG_AW-1:0] r_rdidx;
  logic              w_gpr_wr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (i_set) begin
      r_vld <= 1'b1;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end
  end

  // NOTE: payload fields are qualified by r_vld, so they load only on allocation and carry no reset.
  always_ff @(posedge clk) begin
    if (i_set && !i_flush) begin
      r_rdwen <= i_rdwen;
      r_llbit <= i_llbit;
      r_rdidx <= i_rdidx;
    end
  end

  // $zero is never a real producer, so it cannot create a hazard.
  assign w_gpr_wr    = r_vld & r_rdwen & (r_rdidx != '0);
  assign o_rs1_hit   = w_gpr_wr & (r_rdidx == i_rs1_idx);
  assign o_rs2_hit   = w_gpr_wr & (r_rdidx == i_rs2_idx);
  assign o_rd_hit    = w_gpr_wr & (r_rdidx == i_rd_idx);
  assign o_llbit_hit = r_vld & r_llbit;

endmodule

// File: rtl/oitf_scoreboard.sv
// Outstanding-instruction-track FIFO: in-order alloc/retire with RAW/WAW/LLbit hazard flags for decode.
module oitf_scoreboard #(
  parameter int DEPTH  = oitf_pkg::OITF_DEPTH_DEF,
  parameter int REG_AW = oitf_pkg::REG_AW
) (
  input  logic             clk,
  input  logic             rst,
  oitf_scoreboard_if.slave sb
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [PTR_W:0]   r_alc_ptr;
  logic [PTR_W:0]   r_ret_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_alc_fire;
  logic             w_ret_fire;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_rs1_hit;
  logic [DEPTH-1:0] w_rs2_hit;
  logic [DEPTH-1:0] w_rd_hit;
  logic [DEPTH-1:0] w_llbit_hit;

  // Pointers carry a wrap bit so full and empty are distinguishable with equal indices.
  assign w_empty = (r_alc_ptr == r_ret_ptr);
  assign w_full  = (r_alc_ptr[PTR_W-1:0] == r_ret_ptr[PTR_W-1:0]) &&
                   (r_alc_ptr[PTR_W] != r_ret_ptr[PTR_W]);

  assign w_alc_fire = sb.alc_vld & ~w_full  & ~sb.flush;
  assign w_ret_fire = sb.ret_vld & ~w_empty & ~sb.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alc_ptr <= '0;
      r_ret_ptr <= '0;
    end else if (sb.flush) begin
      r_alc_ptr <= '0;
      r_ret_ptr <= '0;
    end else begin
      if (w_alc_fire) r_alc_ptr <= r_alc_ptr + PTR_ONE;
      if (w_ret_fire) r_ret_ptr <= r_ret_ptr + PTR_ONE;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign w_set[gi] = w_alc_fire && (r_alc_ptr[PTR_W-1:0] == PTR_W'(gi));
    assign w_clr[gi] = w_ret_fire && (r_ret_ptr[PTR_W-1:0] == PTR_W'(gi));

    oitf_entry #(.REG_AW(REG_AW)) u_entry (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (sb.flush),
      .i_set       (w_set[gi]),
      .i_clr       (w_clr[gi]),
      .i_rdidx     (sb.alc_rdidx),
      .i_rdwen     (sb.alc_rdwen),
      .i_llbit     (sb.alc_llbit),
      .i_rs1_idx   (sb.rs1_idx),
      .i_rs2_idx   (sb.rs2_idx),
      .i_rd_idx    (sb.rd_idx),
      .o_rs1_hit   (w_rs1_hit[gi]),
      .o_rs2_hit   (w_rs2_hit[gi]),
      .o_rd_hit    (w_rd_hit[gi]),
      .o_llbit_hit (w_llbit_hit[gi])
    );
  end

  assign sb.alc_rdy     = ~w_full;
  assign sb.alc_ptr     = r_alc_ptr[PTR_W-1:0];
  assign sb.ret_ptr     = r_ret_ptr[PTR_W-1:0];
  assign sb.empty       = w_empty;
  assign sb.full        = w_full;
  assign sb.count       = r_alc_ptr - r_ret_ptr;
  assign sb.rs1_match   = sb.rs1_en   & (|w_rs1_hit);
  assign sb.rs2_match   = sb.rs2_en   & (|w_rs2_hit);
  assign sb.rd_match    = sb.rd_en    & (|w_rd_hit);
  assign sb.llbit_match = sb.llbit_rd & (|w_llbit_hit);

endmodule

// File: tb/tb_oitf_scoreboard.sv
// Directed bench for oitf_scoreboard (DEPTH=4): reset, matching, full, llbit, wrap, flush, async reset.
module tb_oitf_scoreboard;
  import oitf_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_alc = 0;
  int   exp_ret = 0;

  always #5 clk = ~clk;

  oitf_scoreboard_if #(.DEPTH(DEPTH), .REG_AW(REG_AW)) sb ();

  oitf_scoreboard #(.DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb.flush = 0; sb.alc_vld = 0; sb.alc_rdidx = 0; sb.alc_rdwen = 0; sb.alc_llbit = 0;
    sb.ret_vld = 0; sb.rs1_en = 0; sb.rs2_en = 0; sb.rd_en = 0;
    sb.rs1_idx = 0; sb.rs2_idx = 0; sb.rd_idx = 0; sb.llbit_rd = 0;
  endtask

  task automatic alloc(input logic [REG_AW-1:0] idx, input logic wen, input logic ll);
    sb.alc_vld = 1; sb.alc_rdidx = idx; sb.alc_rdwen = wen; sb.alc_llbit = ll;
    tick();
    sb.alc_vld = 0; sb.alc_rdidx = 0; sb.alc_rdwen = 0; sb.alc_llbit = 0;
    exp_alc++;
  endtask

  task automatic retire();
    sb.ret_vld = 1;
    tick();
    sb.ret_vld = 0;
    exp_ret++;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    tick();
    sb.rs1_en = 1; sb.rs1_idx = 5; sb.rd_en = 1; sb.rd_idx = 5; sb.llbit_rd = 1;
    #1;
    checks++; if (sb.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0d expected 1", sb.empty); end
    checks++; if (sb.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0d expected 0", sb.full); end
    checks++; if (sb.alc_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0d expected 1", sb.alc_rdy); end
    checks++; if (sb.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", sb.count); end
    checks++; if (sb.alc_ptr !== 2'd0 || sb.ret_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptrs: got %0d/%0d expected 0/0", sb.alc_ptr, sb.ret_ptr); end
    checks++; if ({sb.rs1_match, sb.rd_match, sb.llbit_match} !== 3'b000) begin errors++; $display("FAIL reset_matches: got %b expected 000", {sb.rs1_match, sb.rd_match, sb.llbit_match}); end
    idle();
  endtask

  task automatic test_match_basic();
    alloc(5'd5, 1'b1, 1'b0);
    checks++; if (sb.count !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", sb.count); end
    checks++; if (sb.empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %0d expected 0", sb.empty); end
    checks++; if (sb.alc_ptr !== 2'd1) begin errors++; $display("FAIL basic_alc_ptr: got %0d expected 1", sb.alc_ptr); end
    sb.rs1_en = 1; sb.rs1_idx = 5; #1;
    checks++; if (sb.rs1_match !== 1'b1) begin errors++; $display("FAIL basic_rs1_hit: got %0d expected 1", sb.rs1_match); end
    sb.rs1_idx = 6; #1;
    checks++; if (sb.rs1_match !== 1'b0) begin errors++; $display("FAIL basic_rs1_miss: got %0d expected 0", sb.rs1_match); end
    sb.rd_en = 1; sb.rd_idx = 5; sb.rs2_en = 0; sb.rs2_idx = 5; #1;
    checks++; if (sb.rd_match !== 1'b1) begin errors++; $display("FAIL basic_rd_hit: got %0d expected 1", sb.rd_match); end
    checks++; if (sb.rs2_match !== 1'b0) begin errors++; $display("FAIL basic_rs2_disabled: got %0d expected 0", sb.rs2_match); end
    sb.rs2_en = 1; #1;
    checks++; if (sb.rs2_match !== 1'b1) begin errors++; $display("FAIL basic_rs2_hit: got %0d expected 1", sb.rs2_match); end
    retire();
    checks++; if (sb.count !== 3'd0 || sb.empty !== 1'b1) begin errors++; $display("FAIL basic_retire: got count=%0d empty=%0d expected 0/1", sb.count, sb.empty); end
    checks++; if (sb.rd_match !== 1'b0) begin errors++; $display("FAIL basic_rd_after_retire: got %0d expected 0", sb.rd_match); end
    checks++; if (sb.ret_ptr !== 2'd1) begin errors++; $display("FAIL basic_ret_ptr: got %0d expected 1", sb.ret_ptr); end
    idle();
  endtask

  task automatic test_full();
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (sb.alc_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_before_%0d: got %0d expected 1", i, sb.alc_rdy); end
      alloc(REG_AW'(i), 1'b1, 1'b0);
    end
    checks++; if (sb.full !== 1'b1 || sb.alc_rdy !== 1'b0) begin errors++; $display("FAIL full_flags: got full=%0d rdy=%0d expected 1/0", sb.full, sb.alc_rdy); end
    checks++; if (sb.count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", sb.count); end
    sb.alc_vld = 1; sb.alc_rdidx = 9; sb.alc_rdwen = 1;
    tick();
    sb.alc_vld = 0;
    checks++; if (sb.count !== 3'd4 || sb.alc_ptr !== 2'(exp_alc)) begin errors++; $display("FAIL full_ignore: got count=%0d alc_ptr=%0d expected 4/%0d", sb.count, sb.alc_ptr, exp_alc % 4); end
    sb.rs1_en = 1; sb.rs1_idx = 9; #1;
    checks++; if (sb.rs1_match !== 1'b0) begin errors++; $display("FAIL full_ignored_entry: got %0d expected 0", sb.rs1_match); end
    sb.alc_vld = 1; sb.alc_rdidx = 10; sb.alc_rdwen = 1; sb.ret_vld = 1;
    tick();
    sb.alc_vld = 0; sb.ret_vld = 0;
    exp_ret++;
    checks++; if (sb.count !== 3'd3 || sb.full !== 1'b0) begin errors++; $display("FAIL full_alc_ret: got count=%0d full=%0d expected 3/0", sb.count, sb.full); end
    checks++; if (sb.ret_ptr !== 2'(exp_ret) || sb.alc_ptr !== 2'(exp_alc)) begin errors++; $display("FAIL full_alc_ret_ptrs: got %0d/%0d expected %0d/%0d", sb.alc_ptr, sb.ret_ptr, exp_alc % 4, exp_ret % 4); end
    sb.rs1_idx = 10; sb.rs2_en = 1; sb.rs2_idx = 1; sb.rd_en = 1; sb.rd_idx = 2; #1;
    checks++; if ({sb.rs1_match, sb.rs2_match, sb.rd_match} !== 3'b001) begin errors++; $display("FAIL full_alc_ret_match: got %b expected 001", {sb.rs1_match, sb.rs2_match, sb.rd_match}); end
    repeat (3) retire();
    checks++; if (sb.empty !== 1'b1 || sb.count !== 3'd0) begin errors++; $display("FAIL full_drain: got empty=%0d count=%0d expected 1/0", sb.empty, sb.count); end
    idle();
  endtask

  task automatic test_llbit();
    alloc(5'd0, 1'b0, 1'b1);
    alloc(5'd0, 1'b1, 1'b0);
    sb.llbit_rd = 1; sb.rs1_en = 1; sb.rs1_idx = 0; sb.rd_en = 1; sb.rd_idx = 0; #1;
    checks++; if (sb.llbit_match !== 1'b1) begin errors++; $display("FAIL llbit_hit: got %0d expected 1", sb.llbit_match); end
    checks++; if (sb.rs1_match !== 1'b0 || sb.rd_match !== 1'b0) begin errors++; $display("FAIL llbit_zero_idx: got rs1=%0d rd=%0d expected 0/0", sb.rs1_match, sb.rd_match); end
    sb.llbit_rd = 0; #1;
    checks++; if (sb.llbit_match !== 1'b0) begin errors++; $display("FAIL llbit_disabled: got %0d expected 0", sb.llbit_match); end
    sb.llbit_rd = 1;
    retire();
    checks++; if (sb.llbit_match !== 1'b0 || sb.count !== 3'd1) begin errors++; $display("FAIL llbit_after_retire: got match=%0d count=%0d expected 0/1", sb.llbit_match, sb.count); end
    retire();
    idle();
  endtask

  task automatic test_wrap();
    alloc(5'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 6; i++) begin
      sb.alc_vld = 1; sb.alc_rdidx = REG_AW'(i); sb.alc_rdwen = 1; sb.ret_vld = 1;
      tick();
      sb.alc_vld = 0; sb.ret_vld = 0;
      exp_alc++; exp_ret++;
      checks++; if (sb.count !== 3'd1 || sb.full !== 1'b0) begin errors++; $display("FAIL wrap_count_%0d: got count=%0d full=%0d expected 1/0", i, sb.count, sb.full); end
      checks++; if (sb.alc_ptr !== 2'(exp_alc) || sb.ret_ptr !== 2'(exp_ret)) begin errors++; $display("FAIL wrap_ptrs_%0d: got %0d/%0d expected %0d/%0d", i, sb.alc_ptr, sb.ret_ptr, exp_alc % 4, exp_ret % 4); end
    end
    sb.rs1_en = 1; sb.rs1_idx = 6; sb.rs2_en = 1; sb.rs2_idx = 5; #1;
    checks++; if ({sb.rs1_match, sb.rs2_match} !== 2'b10) begin errors++; $display("FAIL wrap_match: got %b expected 10", {sb.rs1_match, sb.rs2_match}); end
    retire();
    checks++; if (sb.empty !== 1'b1 || sb.rs1_match !== 1'b0) begin errors++; $display("FAIL wrap_drain: got empty=%0d rs1=%0d expected 1/0", sb.empty, sb.rs1_match); end
    idle();
  endtask

  task automatic test_flush();
    oitf_entry_t vec [3];
    vec[0] = '{vld: 1'b1, rdwen: 1'b1, llbit: 1'b0, rdidx: 5'd7};
    vec[1] = '{vld: 1'b1, rdwen: 1'b1, llbit: 1'b1, rdidx: 5'd8};
    vec[2] = '{vld: 1'b1, rdwen: 1'b1, llbit: 1'b0, rdidx: 5'd9};
    foreach (vec[i]) alloc(vec[i].rdidx, vec[i].rdwen, vec[i].llbit);
    sb.rs1_en = 1; sb.rs1_idx = 7; sb.rd_en = 1; sb.rd_idx = 8; sb.llbit_rd = 1; sb.rs2_en = 1; sb.rs2_idx = 10; #1;
    checks++; if ({sb.rs1_match, sb.rd_match, sb.llbit_match} !== 3'b111 || sb.count !== 3'd3) begin errors++; $display("FAIL flush_pre: got %b count=%0d expected 111/3", {sb.rs1_match, sb.rd_match, sb.llbit_match}, sb.count); end
    sb.flush = 1; sb.alc_vld = 1; sb.alc_rdidx = 10; sb.alc_rdwen = 1; sb.ret_vld = 1;
    tick();
    idle();
    exp_alc = 0; exp_ret = 0;
    sb.rs1_en = 1; sb.rs1_idx = 7; sb.rd_en = 1; sb.rd_idx = 8; sb.llbit_rd = 1; sb.rs2_en = 1; sb.rs2_idx = 10; #1;
    checks++; if (sb.empty !== 1'b1 || sb.count !== 3'd0) begin errors++; $display("FAIL flush_occupancy: got empty=%0d count=%0d expected 1/0", sb.empty, sb.count); end
    checks++; if (sb.alc_ptr !== 2'd0 || sb.ret_ptr !== 2'd0) begin errors++; $display("FAIL flush_ptrs: got %0d/%0d expected 0/0", sb.alc_ptr, sb.ret_ptr); end
    checks++; if ({sb.rs1_match, sb.rs2_match, sb.rd_match, sb.llbit_match} !== 4'b0000) begin errors++; $display("FAIL flush_matches: got %b expected 0000", {sb.rs1_match, sb.rs2_match, sb.rd_match, sb.llbit_match}); end
    idle();
  endtask

  task automatic test_empty_retire_and_async_reset();
    retire();
    exp_ret--;
    checks++; if (sb.count !== 3'd0 || sb.empty !== 1'b1 || sb.ret_ptr !== 2'd0) begin errors++; $display("FAIL empty_retire: got count=%0d empty=%0d ret_ptr=%0d expected 0/1/0", sb.count, sb.empty, sb.ret_ptr); end
    alloc(5'd3, 1'b1, 1'b0);
    alloc(5'd4, 1'b1, 1'b1);
    sb.rs1_en = 1; sb.rs1_idx = 3; sb.llbit_rd = 1; #1;
    checks++; if (sb.count !== 3'd2 || sb.rs1_match !== 1'b1 || sb.llbit_match !== 1'b1) begin errors++; $display("FAIL pre_reset: got count=%0d rs1=%0d ll=%0d expected 2/1/1", sb.count, sb.rs1_match, sb.llbit_match); end
    rst = 1; #1;
    checks++; if (sb.count !== 3'd0 || sb.empty !== 1'b1 || sb.alc_ptr !== 2'd0 || sb.alc_rdy !== 1'b1) begin errors++; $display("FAIL async_reset_state: got count=%0d empty=%0d alc_ptr=%0d rdy=%0d expected 0/1/0/1", sb.count, sb.empty, sb.alc_ptr, sb.alc_rdy); end
    checks++; if (sb.rs1_match !== 1'b0 || sb.llbit_match !== 1'b0) begin errors++; $display("FAIL async_reset_matches: got rs1=%0d ll=%0d expected 0/0", sb.rs1_match, sb.llbit_match); end
    tick();
    rst = 0;
    exp_alc = 0; exp_ret = 0;
    idle();
    alloc(5'd12, 1'b1, 1'b0);
    sb.rs1_en = 1; sb.rs1_idx = 12; #1;
    checks++; if (sb.count !== 3'd1 || sb.rs1_match !== 1'b1 || sb.alc_ptr !== 2'd1) begin errors++; $display("FAIL post_reset_alloc: got count=%0d rs1=%0d alc_ptr=%0d expected 1/1/1", sb.count, sb.rs1_match, sb.alc_ptr); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_match_basic();
    test_full();
    test_llbit();
    test_wrap();
    test_flush();
    test_empty_retire_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
